// File: rtl/addsub_pipe_n.sv
// Segmented-carry add/subtract pipeline: one SEG-bit slice per stage, followed by a
// registered output stage that applies optional signed saturation. Stalls freeze everything.
module addsub_pipe_n #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Add_ctrl,
  input  logic             Sat_ctrl,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] SUM,
  output logic             C_out,
  output logic             O,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  // Per-stage state: operands (B already conditionally inverted), partial result, carry, flags.
  logic [WIDTH-1:0]  a_r   [STAGES];
  logic [WIDTH-1:0]  bp_r  [STAGES];
  logic [WIDTH-1:0]  sum_r [STAGES];
  logic [STAGES-1:0] cy_r;
  logic [STAGES-1:0] vld_r;
  logic [STAGES-1:0] sat_r;

  logic [WIDTH-1:0]  in_a_s    [STAGES];
  logic [WIDTH-1:0]  in_bp_s   [STAGES];
  logic [WIDTH-1:0]  in_sum_s  [STAGES];
  logic [WIDTH-1:0]  nxt_sum_s [STAGES];
  logic [STAGES-1:0] in_cy_s;
  logic [STAGES-1:0] in_vld_s;
  logic [STAGES-1:0] in_sat_s;
  logic [STAGES-1:0] nxt_cy_s;
  logic [SEG:0]      slice_s;

  logic              stall_s;
  logic [WIDTH-1:0]  raw_s;
  logic              ovf_s;
  logic [WIDTH-1:0]  res_s;

  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                input logic sat, input logic ovf);
    logic [WIDTH-1:0] res;
    if (sat && ovf) begin
      // Overflow flips the sign bit, so a set raw MSB means the true result was positive.
      res = raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      res = raw;
    end
    return res;
  endfunction

  assign stall_s  = out_valid & ~out_ready;
  assign in_ready = ~stall_s;

  // Stage inputs and the slice adder for each stage.
  always_comb begin
    in_cy_s  = {STAGES{1'b0}};
    in_vld_s = {STAGES{1'b0}};
    in_sat_s = {STAGES{1'b0}};
    nxt_cy_s = {STAGES{1'b0}};
    slice_s  = {(SEG+1){1'b0}};
    for (int s = 0; s < STAGES; s++) begin
      in_a_s[s]    = {WIDTH{1'b0}};
      in_bp_s[s]   = {WIDTH{1'b0}};
      in_sum_s[s]  = {WIDTH{1'b0}};
      nxt_sum_s[s] = {WIDTH{1'b0}};
    end

    in_a_s[0]   = A;
    in_bp_s[0]  = Add_ctrl ? B : ~B;
    in_cy_s[0]  = ~Add_ctrl;
    in_vld_s[0] = in_valid;
    in_sat_s[0] = Sat_ctrl;
    for (int s = 1; s < STAGES; s++) begin
      in_a_s[s]   = a_r[s-1];
      in_bp_s[s]  = bp_r[s-1];
      in_sum_s[s] = sum_r[s-1];
      in_cy_s[s]  = cy_r[s-1];
      in_vld_s[s] = vld_r[s-1];
      in_sat_s[s] = sat_r[s-1];
    end

    for (int s = 0; s < STAGES; s++) begin
      slice_s = {1'b0, in_a_s[s][s*SEG +: SEG]} + {1'b0, in_bp_s[s][s*SEG +: SEG]}
              + {{SEG{1'b0}}, in_cy_s[s]};
      nxt_sum_s[s]               = in_sum_s[s];
      nxt_sum_s[s][s*SEG +: SEG] = slice_s[SEG-1:0];
      nxt_cy_s[s]                = slice_s[SEG];
    end
  end

  // Overflow = carry into MSB ^ carry out; carry into MSB is recovered as a ^ b' ^ sum at the MSB.
  always_comb begin
    raw_s = sum_r[LAST];
    ovf_s = cy_r[LAST] ^ a_r[LAST][WIDTH-1] ^ bp_r[LAST][WIDTH-1] ^ raw_s[WIDTH-1];
    res_s = saturate(raw_s, sat_r[LAST], ovf_s);
  end

  // Pipeline and output registers: reset clears, stall holds, otherwise advance one stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r     <= {STAGES{1'b0}};
      cy_r      <= {STAGES{1'b0}};
      sat_r     <= {STAGES{1'b0}};
      for (int s = 0; s < STAGES; s++) begin
        a_r[s]   <= {WIDTH{1'b0}};
        bp_r[s]  <= {WIDTH{1'b0}};
        sum_r[s] <= {WIDTH{1'b0}};
      end
      out_valid <= 1'b0;
      SUM       <= {WIDTH{1'b0}};
      C_out     <= 1'b0;
      O         <= 1'b0;
    end else if (!stall_s) begin
      for (int s = 0; s < STAGES; s++) begin
        a_r[s]   <= in_a_s[s];
        bp_r[s]  <= in_bp_s[s];
        sum_r[s] <= nxt_sum_s[s];
        cy_r[s]  <= nxt_cy_s[s];
        vld_r[s] <= in_vld_s[s];
        sat_r[s] <= in_sat_s[s];
      end
      out_valid <= vld_r[LAST];
      SUM       <= res_s;
      C_out     <= cy_r[LAST];
      O         <= ovf_s;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_addsub_pipe_n.sv
// Scoreboard bench for addsub_pipe_n: driver pushes model results on accepted inputs,
// an independent monitor pops and compares on each output transfer.
module tb_addsub_pipe_n;
  localparam int W   = 16;
  localparam int S   = 4;
  localparam int LAT = W / S;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] A, B, SUM;
  logic         Add_ctrl, Sat_ctrl, in_valid, in_ready, C_out, O, out_valid, out_ready;

  typedef struct {
    logic [W-1:0] sum;
    logic         c;
    logic         o;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: never ready
  bit   lat_chk  = 1'b0;

  addsub_pipe_n #(.WIDTH(W), .SEG(S)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .Add_ctrl(Add_ctrl), .Sat_ctrl(Sat_ctrl),
    .in_valid(in_valid), .in_ready(in_ready), .SUM(SUM), .C_out(C_out), .O(O),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s", nm);
  endtask

  // Reference: plain integer arithmetic on the operands, no slicing or carry chains.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic add, input logic sat);
    exp_t m;
    int ua = int'(a);
    int ub = int'(b);
    int sr = add ? (int'($signed(a)) + int'($signed(b))) : (int'($signed(a)) - int'($signed(b)));
    m.sum = add ? W'(ua + ub) : W'(ua - ub);
    m.c   = add ? ((ua + ub) > 65535) : (ua >= ub);
    m.o   = (sr > 32767) || (sr < -32768);
    if (sat && m.o) m.sum = (sr > 0) ? 16'h7FFF : 16'h8000;
    m.cyc = 0;
    return m;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
    exp_t m;
    m.sum = s; m.c = c; m.o = o; m.cyc = 0;
    return m;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic add, input logic sat, input exp_t e, output bit acc);
    @(negedge clk);
    in_valid = v; A = a; B = b; Add_ctrl = add; Sat_ctrl = sat;
    #1;
    acc = v && in_ready;
    if (acc) begin
      e.cyc = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic add, input logic sat, input exp_t e);
    bit acc = 1'b0;
    int n   = 0;
    while (!acc && n < 200) begin
      drive(1'b1, a, b, add, sat, e, acc);
      n++;
    end
    if (!acc) fail_now("send_timeout");
  endtask

  task automatic send_rand();
    logic [W-1:0] a = W'($urandom());
    logic [W-1:0] b = W'($urandom());
    logic add = 1'($urandom());
    logic sat = 1'($urandom());
    send(a, b, add, sat, model(a, b, add, sat));
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, mk(16'h0000, 1'b0, 1'b0), acc);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      idle(1);
      #2;
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Monitor: drives out_ready, checks in_ready, stall stability and scoreboard order.
  initial begin
    exp_t        e;
    logic [18:0] held   = 19'h0;
    bit          hold_v = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom());
        default: out_ready = 1'b0;
      endcase
      #2;
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (hold_v) chk("stall_hold", {out_valid, O, C_out, SUM}, held);
      hold_v = 1'b0;
      if (out_valid && !out_ready && !rst) begin
        hold_v = 1'b1;
        held   = {out_valid, O, C_out, SUM};
      end
      if (out_valid && out_ready && !rst) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          e = exp_q.pop_front();
          chk("result", {O, C_out, SUM}, {e.o, e.c, e.sum});
          // cyc is sampled at the negedge before the accepting edge, hence LAT+1.
          if (lat_chk) chk("latency", cyc - e.cyc, LAT + 1);
        end
      end
    end
  end

  initial begin
    bit acc;
    rst = 1'b1; in_valid = 1'b0; A = 16'h0000; B = 16'h0000; Add_ctrl = 1'b1; Sat_ctrl = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", SUM, 16'h0000);
    chk("rst_cout", C_out, 0);
    chk("rst_o", O, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    lat_chk = 1'b1;
    send(16'h7FFF, 16'h0001, 1'b1, 1'b0, mk(16'h8000, 1'b0, 1'b1));
    send(16'h7FFF, 16'h0001, 1'b1, 1'b1, mk(16'h7FFF, 1'b0, 1'b1));
    send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h8000, 1'b1, 1'b1));
    send(16'h8000, 16'h0001, 1'b0, 1'b0, mk(16'h7FFF, 1'b1, 1'b1));
    send(16'hFFFF, 16'h0001, 1'b1, 1'b0, mk(16'h0000, 1'b1, 1'b0));
    send(16'h0000, 16'h0001, 1'b0, 1'b0, mk(16'hFFFF, 1'b0, 1'b0));
    send(16'h0005, 16'h0003, 1'b0, 1'b0, mk(16'h0002, 1'b1, 1'b0));
    send(16'h8000, 16'h8000, 1'b1, 1'b1, mk(16'h8000, 1'b1, 1'b1));
    wait_drain();

    for (int i = 0; i < 10000; i++) send_rand();
    wait_drain();

    lat_chk  = 1'b0;
    rdy_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] a = W'($urandom());
      logic [W-1:0] b = W'($urandom());
      logic add = 1'($urandom());
      logic sat = 1'($urandom());
      drive(1'($urandom()), a, b, add, sat, model(a, b, add, sat), acc);
    end
    rdy_mode = 0;
    wait_drain();

    // Reset with three results in flight and downstream blocked.
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) send_rand();
    idle(2);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", SUM, 16'h0000);
    rst = 1'b0;
    rdy_mode = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      chk("no_stale", out_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/addsub_pipe_n.md
ADDSUB_PIPE_N -- requirements
Module: addsub_pipe_n

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of SEG, minimum 4.
REQ-002 Parameter SEG, default 4, bits summed per pipeline stage; STAGES = WIDTH/SEG.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 A  input  WIDTH  operand A (two's complement or unsigned).
REQ-006 B  input  WIDTH  operand B.
REQ-007 Add_ctrl  input  1  1 = A+B, 0 = A-B.
REQ-008 Sat_ctrl  input  1  1 = clamp signed overflow to signed max/min.
REQ-009 in_valid  input  1  A/B/Add_ctrl/Sat_ctrl valid this cycle.
REQ-010 in_ready  output  1  block accepts an operand set this cycle.
REQ-011 SUM  output  WIDTH  result.
REQ-012 C_out  output  1  carry out of MSB.
REQ-013 O  output  1  signed overflow flag.
REQ-014 out_valid  output  1  SUM/C_out/O valid.
REQ-015 out_ready  input  1  downstream accepts result this cycle.

Function
REQ-016 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready.
REQ-017 Stall = out_valid && !out_ready; in_ready SHALL equal !stall (combinational).
REQ-018 While stall, every stage register (data, carry, valid, control) SHALL hold; otherwise all stages advance one position per cycle.
REQ-019 Stage k (0..STAGES-1) SHALL add bits [k*SEG+SEG-1 : k*SEG] of A and B' plus the carry from stage k-1; unprocessed upper slices and finished lower result slices travel alongside.
REQ-020 B' = B when Add_ctrl=1, ~B when Add_ctrl=0; carry into stage 0 = ~Add_ctrl.
REQ-021 Latency: an operand set accepted at edge t SHALL present out_valid=1 with its result after edge t+STAGES when no stall occurs; throughput one result per cycle.
REQ-022 Bubbles (in_valid=0 while in_ready=1) SHALL propagate as valid=0 stage entries; no reordering, no duplication, no loss.
REQ-023 C_out = carry out of bit WIDTH-1 of A + B' + cin (subtract: 1 = no borrow).
REQ-024 O = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-025 If Sat_ctrl=1 and O=1: SUM SHALL be 2^(WIDTH-1)-1 when the raw MSB is 1 (positive overflow), 2^(WIDTH-1) when raw MSB is 0; C_out and O report raw values.
REQ-026 Add_ctrl and Sat_ctrl SHALL be captured with the operands and travel with them; later input changes SHALL not affect in-flight results.
REQ-027 Outputs SHALL be registered (final stage); no combinational path from A/B to SUM.
REQ-028 A stalled result SHALL remain stable on SUM/C_out/O/out_valid until accepted.

Reset
REQ-029 While rst=1 at an edge: all stage valid bits, out_valid, SUM, C_out, O SHALL become 0; in_ready SHALL read 1 the cycle after reset deasserts.
REQ-030 Reset mid-operation SHALL discard all in-flight results; none SHALL appear after reset.
REQ-031 rst SHALL take priority over in_valid and stall.

Verification (WIDTH=16, SEG=4, latency 4)
REQ-032 Add A=7FFF,B=0001,Sat=0 -> SUM=8000,C_out=0,O=1; same with Sat=1 -> SUM=7FFF,C_out=0,O=1.
REQ-033 Sub A=8000,B=0001,Sat=1 -> SUM=8000,C_out=1,O=1; Sat=0 -> SUM=7FFF.
REQ-034 Add FFFF+0001 -> 0000,C_out=1,O=0; sub 0000-0001 -> FFFF,C_out=0,O=0; sub 0005-0003 -> 0002,C_out=1,O=0.
REQ-035 Back-to-back 10000 random vectors, out_ready=1 -> one result per cycle, 4-cycle latency, all matching {O,C_out,SUM} model.
REQ-036 Random out_ready toggling with random in_valid -> in_ready=!stall every cycle, results in order, held stable while stalled, zero loss/duplication.
REQ-037 Assert rst with 3 results in flight and out_ready=0 -> next cycle out_valid=0, SUM=0000, no stale result ever emitted.
